// File: rtl/parallel_acc_tree.sv
// ---------------------------------------------------------------------------
// parallel_acc_tree
//   Consumer end of the parallel multiplier interface. Each accepted beat of
//   MULT_OPS signed products is reduced in a registered adder tree (one
//   register per level, TREE_DLY = clog2(MULT_OPS) levels). The tree sums are
//   then accumulated over a programmed number of beats. One signed partial sum
//   is emitted with a single-cycle valid strobe.
//
// Ports
//   clk, areset   clock; synchronous active-high reset
//   i_start       start a new accumulation (honoured only when idle)
//   i_beat_num    beats to accumulate, sampled with i_start (0 acts as 1)
//   i_valid       product beat present
//   i_result      MULT_OPS signed lanes, lane k at [k*IN_DATA_BW +: IN_DATA_BW]
//   o_idle/o_busy FSM idle / not idle
//   o_valid       one-cycle strobe, o_acc is final
//   o_acc         signed accumulated sum, held until the next accepted start
//   o_drop_err    sticky: a beat arrived outside the accumulate phase
//
// Build option
//   PARALLEL_ACC_SAT_EN  saturating accumulator instead of wraparound
// ---------------------------------------------------------------------------
module parallel_acc_tree #(
    parameter int MULT_OPS   = 60,
    parameter int IN_DATA_BW = 16,
    parameter int ACC_BW     = 32,
    parameter int BEAT_BW    = 8
) (
    input  logic                           clk,
    input  logic                           areset,
    input  logic                           i_start,
    input  logic [BEAT_BW-1:0]             i_beat_num,
    input  logic                           i_valid,
    input  logic [MULT_OPS*IN_DATA_BW-1:0] i_result,
    output logic                           o_idle,
    output logic                           o_busy,
    output logic                           o_valid,
    output logic [ACC_BW-1:0]              o_acc,
    output logic                           o_drop_err
);

    // Node count of tree level lvl (level 0 = the input lanes).
    function automatic int lvl_cnt(input int lvl);
        int n;
        n = MULT_OPS;
        for (int unsigned i = 0; i < lvl; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // Flat index of the first node of level lvl.
    function automatic int lvl_off(input int lvl);
        int o;
        o = 0;
        for (int unsigned i = 0; i < lvl; i++) o = o + lvl_cnt(int'(i));
        return o;
    endfunction

    localparam int TREE_DLY  = $clog2(MULT_OPS);
    localparam int REG_NODES = lvl_off(TREE_DLY + 1) - MULT_OPS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ACC_BW-1:0]   lane   [MULT_OPS];
    logic [ACC_BW-1:0]   tree_q [REG_NODES];
    logic [TREE_DLY-1:0] vld_q;
    logic [BEAT_BW-1:0]  cnt_q;
    logic [BEAT_BW-1:0]  n_q;
    logic [ACC_BW-1:0]   acc_q;
    logic [ACC_BW-1:0]   acc_next;
    logic [ACC_BW-1:0]   tree_sum;
    logic                sum_vld;
    logic                drop_q;
    logic                start_acc;
    logic                beat_acc;
    logic                last_beat;

    assign start_acc = (state_q == S_IDLE) && i_start;
    assign beat_acc  = (state_q == S_ACC) && i_valid;
    assign last_beat = beat_acc && ((cnt_q + BEAT_BW'(1)) == n_q);

    // ---------------- adder tree ----------------
    for (genvar k = 0; k < MULT_OPS; k++) begin : g_lane
        assign lane[k] = {{(ACC_BW-IN_DATA_BW){i_result[k*IN_DATA_BW+IN_DATA_BW-1]}},
                          i_result[k*IN_DATA_BW +: IN_DATA_BW]};
    end

    // Level l is stored flat in tree_q starting at lvl_off(l)-MULT_OPS.
    // The unpaired last node of an odd-sized level is added to zero, which
    // keeps it registered and aligned with its siblings.
    for (genvar l = 1; l <= TREE_DLY; l++) begin : g_lvl
        localparam int CUR_N = lvl_cnt(l);
        localparam int PRV_N = lvl_cnt(l - 1);
        localparam int CUR_O = lvl_off(l) - MULT_OPS;
        localparam int PRV_O = lvl_off(l - 1) - MULT_OPS;
        for (genvar j = 0; j < CUR_N; j++) begin : g_node
            logic [ACC_BW-1:0] opa;
            logic [ACC_BW-1:0] opb;
            if (l == 1) begin : g_from_lane
                assign opa = lane[2*j];
                if (2*j + 1 < PRV_N) begin : g_pair
                    assign opb = lane[2*j+1];
                end else begin : g_odd
                    assign opb = '0;
                end
            end else begin : g_from_tree
                assign opa = tree_q[PRV_O + 2*j];
                if (2*j + 1 < PRV_N) begin : g_pair
                    assign opb = tree_q[PRV_O + 2*j + 1];
                end else begin : g_odd
                    assign opb = '0;
                end
            end
            always_ff @(posedge clk) begin
                if (areset) tree_q[CUR_O + j] <= '0;
                else        tree_q[CUR_O + j] <= opa + opb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= beat_acc;
            for (int unsigned i = 1; i < TREE_DLY; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    assign tree_sum = tree_q[REG_NODES-1];
    assign sum_vld  = vld_q[TREE_DLY-1];

    // ---------------- accumulator ----------------
`ifdef PARALLEL_ACC_SAT_EN
    logic [ACC_BW:0] acc_wide;
    assign acc_wide = {acc_q[ACC_BW-1], acc_q} + {tree_sum[ACC_BW-1], tree_sum};
    always_comb begin
        acc_next = acc_wide[ACC_BW-1:0];
        // Top two bits disagree: the sum left the ACC_BW range, clamp by sign.
        if (acc_wide[ACC_BW] != acc_wide[ACC_BW-1]) begin
            acc_next = acc_wide[ACC_BW] ? {1'b1, {(ACC_BW-1){1'b0}}}
                                        : {1'b0, {(ACC_BW-1){1'b1}}};
        end
    end
`else
    assign acc_next = acc_q + tree_sum;
`endif

    always_ff @(posedge clk) begin
        if (areset)       acc_q <= '0;
        else if (start_acc) acc_q <= '0;
        else if (sum_vld) acc_q <= acc_next;
    end

    // ---------------- beat bookkeeping ----------------
    always_ff @(posedge clk) begin
        if (areset) begin
            cnt_q <= '0;
            n_q   <= '0;
        end else if (start_acc) begin
            cnt_q <= '0;
            n_q   <= (i_beat_num == '0) ? BEAT_BW'(1) : i_beat_num;
        end else if (beat_acc) begin
            cnt_q <= cnt_q + BEAT_BW'(1);
        end
    end

    // Clear on an accepted start wins over a beat dropped in the same cycle.
    always_ff @(posedge clk) begin
        if (areset)                            drop_q <= 1'b0;
        else if (start_acc)                    drop_q <= 1'b0;
        else if (i_valid && state_q != S_ACC)  drop_q <= 1'b1;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (areset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start)   state_d = S_ACC;
            S_ACC:   if (last_beat) state_d = S_FLUSH;
            // Empty valid pipe means the final tree sum was already added.
            S_FLUSH: if (vld_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_idle  = (state_q == S_IDLE);
        o_busy  = (state_q != S_IDLE);
        o_valid = (state_q == S_DONE);
    end

    assign o_acc      = acc_q;
    assign o_drop_err = drop_q;

endmodule

// File: tb/tb_parallel_acc_tree.sv
module tb_parallel_acc_tree;
    localparam int MULT_OPS   = 60;
    localparam int IN_DATA_BW = 16;
    localparam int ACC_BW     = 32;
    localparam int ACC_BW_S   = 24;
    localparam int BEAT_BW    = 8;
    localparam int TREE_DLY   = $clog2(MULT_OPS);
    localparam int VW         = MULT_OPS * IN_DATA_BW;

    logic               clk;
    logic               areset;
    logic               i_start;
    logic [BEAT_BW-1:0] i_beat_num;
    logic               i_valid;
    logic [VW-1:0]      i_result;

    logic                o_idle, o_busy, o_valid, o_drop_err;
    logic [ACC_BW-1:0]   o_acc;
    logic                s_idle, s_busy, s_valid, s_drop_err;
    logic [ACC_BW_S-1:0] s_acc;

    parallel_acc_tree #(
        .MULT_OPS(MULT_OPS), .IN_DATA_BW(IN_DATA_BW), .ACC_BW(ACC_BW), .BEAT_BW(BEAT_BW)
    ) dut (
        .clk(clk), .areset(areset), .i_start(i_start), .i_beat_num(i_beat_num),
        .i_valid(i_valid), .i_result(i_result), .o_idle(o_idle), .o_busy(o_busy),
        .o_valid(o_valid), .o_acc(o_acc), .o_drop_err(o_drop_err)
    );

    parallel_acc_tree #(
        .MULT_OPS(MULT_OPS), .IN_DATA_BW(IN_DATA_BW), .ACC_BW(ACC_BW_S), .BEAT_BW(BEAT_BW)
    ) dut_s (
        .clk(clk), .areset(areset), .i_start(i_start), .i_beat_num(i_beat_num),
        .i_valid(i_valid), .i_result(i_result), .o_idle(s_idle), .o_busy(s_busy),
        .o_valid(s_valid), .o_acc(s_acc), .o_drop_err(s_drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint lanes_total(input logic [VW-1:0] r);
        longint s;
        s = 0;
        for (int k = 0; k < MULT_OPS; k++)
            s += longint'($signed(r[k*IN_DATA_BW +: IN_DATA_BW]));
        return s;
    endfunction

    function automatic longint acc_step(input longint a, input longint b, input int bw);
        longint s, hi, lo;
        s  = a + b;
        hi = (longint'(1) <<< (bw - 1)) - 1;
        lo = -hi - 1;
`ifdef PARALLEL_ACC_SAT_EN
        if (s > hi) s = hi;
        else if (s < lo) s = lo;
`else
        while (s > hi) s -= (longint'(1) <<< bw);
        while (s < lo) s += (longint'(1) <<< bw);
`endif
        return s;
    endfunction

    int     cyc = 0;
    bit     ready = 0;
    bit     m_in_acc = 0, m_have_due = 0, m_drop = 0;
    int     m_due = 0, m_n = 0, m_beats = 0;
    longint m_sum = 0, m_sum_s = 0, held = 0, held_s = 0;
    bit     e_idle = 1, e_valid = 0;

    // Model advances on each clock edge from the sampled inputs.
    always @(posedge clk) begin
        bit busy_pre;
        cyc = cyc + 1;
        if (areset) begin
            ready = 1; m_in_acc = 0; m_have_due = 0; m_drop = 0;
            held = 0; held_s = 0; e_idle = 1; e_valid = 0;
        end else begin
            busy_pre = m_in_acc || (m_have_due && cyc <= m_due + 1);
            if (!busy_pre) begin
                if (i_start) begin
                    m_in_acc = 1; m_have_due = 0; m_drop = 0;
                    m_n = (i_beat_num == 0) ? 1 : int'(i_beat_num);
                    m_beats = 0; m_sum = 0; m_sum_s = 0; held = 0; held_s = 0;
                end else if (i_valid) begin
                    m_drop = 1;
                end
            end else if (m_in_acc) begin
                if (i_valid) begin
                    m_sum   = acc_step(m_sum,   lanes_total(i_result), ACC_BW);
                    m_sum_s = acc_step(m_sum_s, lanes_total(i_result), ACC_BW_S);
                    m_beats++;
                    if (m_beats == m_n) begin
                        m_in_acc = 0; m_have_due = 1;
                        m_due = cyc + TREE_DLY + 1;
                        held = m_sum; held_s = m_sum_s;
                    end
                end
            end else if (i_valid) begin
                m_drop = 1;
            end
            e_idle  = !(m_in_acc || (m_have_due && cyc <= m_due));
            e_valid = m_have_due && (cyc == m_due);
        end
    end

    // Compare process: every cycle after the first reset.
    always @(negedge clk) begin
        if (ready) begin
            chk("valid",   o_valid,    e_valid);
            chk("valid_s", s_valid,    e_valid);
            chk("idle",    o_idle,     e_idle);
            chk("idle_s",  s_idle,     e_idle);
            chk("busy",    o_busy,     !e_idle);
            chk("drop",    o_drop_err, m_drop);
            chk("drop_s",  s_drop_err, m_drop);
            if (e_idle || e_valid) begin
                chk("acc",   longint'($signed(o_acc)), held);
                chk("acc_s", longint'($signed(s_acc)), held_s);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic logic [VW-1:0] fill(input int v);
        logic [VW-1:0] r;
        for (int k = 0; k < MULT_OPS; k++) r[k*IN_DATA_BW +: IN_DATA_BW] = IN_DATA_BW'(v);
        return r;
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] r;
        for (int k = 0; k < MULT_OPS; k++) r[k*IN_DATA_BW +: IN_DATA_BW] = IN_DATA_BW'($urandom);
        return r;
    endfunction

    task automatic start(input int n);
        i_start = 1; i_beat_num = BEAT_BW'(n); step(); i_start = 0;
    endtask

    task automatic beat(input logic [VW-1:0] v);
        i_valid = 1; i_result = v; step(); i_valid = 0;
    endtask

    // Wait (bounded) for o_valid; optionally pin literal results; leave aligned
    // one edge past DONE so the next start lands in IDLE.
    task automatic finish_txn(input string name, input bit lit, input longint e32,
                              input longint e24, output int waited);
        bit found;
        found = 0; waited = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk); waited++;
            if (o_valid) found = 1;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no o_valid expected o_valid within 40 cycles", name);
        end else if (lit) begin
            chk({name, "_acc"},   longint'($signed(o_acc)), e32);
            chk({name, "_acc_s"}, longint'($signed(s_acc)), e24);
        end
        step();
    endtask

    initial begin
        int w;
        logic [VW-1:0] ramp;
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n, eff;
        logic [VW-1:0] ramp;
        areset = 1; i_start = 0; i_valid = 0; i_beat_num = '0; i_result = '0;
        repeat (3) step();
        areset = 0;
        chk("rst_idle", o_idle, 1);
        chk("rst_acc",  longint'($signed(o_acc)), 0);
        chk("rst_drop", o_drop_err, 0);

        // N=3, lanes=1, back-to-back
        start(3);
        repeat (3) beat(fill(1));
        finish_txn("t1", 1, 180, 180, w);
        chk("t1_latency", w, TREE_DLY + 2);
        chk("t1_idle_after", o_idle, 1);

        // N=4, lanes=16384, gaps of 2
        start(4);
        for (int b = 0; b < 4; b++) begin
            beat(fill(16384));
            if (b < 3) repeat (2) step();
        end
        finish_txn("t2", 1, 3932160, 3932160, w);
        chk("t2_drop", o_drop_err, 0);

        // N=0 treated as 1, lanes k-30
        for (int k = 0; k < MULT_OPS; k++) ramp[k*IN_DATA_BW +: IN_DATA_BW] = IN_DATA_BW'(k - 30);
        start(0);
        beat(ramp);
        finish_txn("t3", 1, -30, -30, w);

        // N=16, lanes=16384: 24-bit instance overflows
        start(16);
        repeat (16) beat(fill(16384));
`ifdef PARALLEL_ACC_SAT_EN
        finish_txn("t4", 1, 15728640, 8388607, w);
`else
        finish_txn("t4", 1, 15728640, -1048576, w);
`endif

        // stray beat while idle, then a normal transaction clears the flag
        beat(fill(7));
        repeat (2) step();
        chk("t5_drop_set", o_drop_err, 1);
        start(1);
        beat(fill(2));
        finish_txn("t5", 1, 120, 120, w);
        chk("t5_drop_clr", o_drop_err, 0);

        // start and beat in the same idle cycle: clear wins
        i_start = 1; i_valid = 1; i_beat_num = 1; i_result = fill(5);
        step();
        i_start = 0; i_valid = 0;
        chk("t6_drop", o_drop_err, 0);
        beat(fill(1));
        finish_txn("t6", 1, 60, 60, w);

        // reset mid accumulation
        start(5);
        repeat (2) beat(fill(3));
        areset = 1; step(); areset = 0;
        repeat (10) step();
        chk("t7_acc",  longint'($signed(o_acc)), 0);
        chk("t7_idle", o_idle, 1);
        start(1);
        beat(fill(-1));
        finish_txn("t7", 1, -60, -60, w);

        // randomized transactions against the model
        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(0, 6);
            eff = (n == 0) ? 1 : n;
            if ($urandom_range(0, 3) == 0) begin
                i_valid = 1; i_result = rnd_vec();
            end
            start(n);
            i_valid = 0;
            for (int b = 0; b < eff; b++) begin
                beat(rnd_vec());
                repeat ($urandom_range(0, 2)) begin
                    i_start = ($urandom_range(0, 3) == 0);
                    i_beat_num = BEAT_BW'($urandom);
                    step();
                    i_start = 0;
                end
            end
            if ($urandom_range(0, 2) == 0) beat(rnd_vec());
            if ($urandom_range(0, 9) == 0) begin
                areset = 1; step(); areset = 0;
            end else begin
                finish_txn("rnd", 0, 0, 0, w);
            end
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
